window_buffer: RTL
==================

WINDOW_BUFFER -- requirements
Module: window_buffer

Interface
REQ-001 Parameter DATA_SIZE, default 8: bit width of one pixel.
REQ-002 Parameter IMG_WIDTH, default 28: pixels per image row.
REQ-003 Parameter IMG_HEIGHT, default 28: rows per image frame.
REQ-004 Parameter KERNEL_SIZE, default 3: window edge K; legal range 2 <= K <= min(IMG_WIDTH, IMG_HEIGHT).
REQ-005 Port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port data_valid, input, 1 bit: pixel_in_data is accepted on a rising edge where data_valid = 1.
REQ-008 Port pixel_in_data, input, DATA_SIZE bits: raster-order pixel stream, row-major, unsigned.
REQ-009 Port window_data, output, K*K*DATA_SIZE bits: registered KxK window; element (r,c) at bits [(r*K+c)*DATA_SIZE +: DATA_SIZE]; r=0 is the oldest row, c=0 the oldest column; (K-1,K-1) is the newest pixel.
REQ-010 Port window_valid, output, 1 bit: window_data holds a complete in-frame window.
REQ-011 Port frame_done, output, 1 bit: one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-012 The block SHALL hold K-1 line buffers, each IMG_WIDTH x DATA_SIZE, plus a KxK register window.
REQ-013 On each accepted pixel, every window row SHALL shift left by one column; column K-1 SHALL load the newest pixel (row K-1) and the line-buffer outputs at the current column (rows 0..K-2, oldest in row 0).
REQ-014 On each accepted pixel, line buffers SHALL cascade at the current column: buffer k receives buffer k+1's old value, the newest buffer receives pixel_in_data.
REQ-015 Column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) SHALL advance only on accepted pixels; col wraps to 0 and increments row; at (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0.
REQ-016 window_valid SHALL be 1 in the cycle after an accepted pixel at row >= K-1 and col >= K-1, else 0; latency is exactly one clock.
REQ-017 Windows SHALL never straddle a row boundary: pixels at col < K-1 produce window_valid = 0.
REQ-018 With data_valid = 0, all counters, line buffers and window_data SHALL hold; window_valid SHALL be 0.
REQ-019 Per frame exactly (IMG_HEIGHT-K+1)*(IMG_WIDTH-K+1) window_valid pulses SHALL occur, regardless of data_valid gaps.
REQ-020 frame_done SHALL be 1 for one cycle, coinciding with the final window_valid of the frame.
REQ-021 A new frame SHALL start immediately after wrap with no idle cycles required; stale line-buffer contents SHALL not produce a valid window (gated by row).
REQ-022 Stride is fixed at 1; no padding; no back-pressure input.

Reset
REQ-023 On reset_n = 0, asynchronously: col = 0, row = 0, window_valid = 0, frame_done = 0, window_data = 0.
REQ-024 Line-buffer storage need not be cleared; correctness relies on REQ-021 gating.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; the first accepted pixel after release is pixel (0,0) of a new frame.

Verification (DATA_SIZE=8, IMG_WIDTH=5, IMG_HEIGHT=5, K=3, pixel value = raster index 0..24)
REQ-026 Continuous data_valid=1, pixels 0..24 -> first window_valid the cycle after pixel 12, window (r0..r2) = {0,1,2},{5,6,7},{10,11,12}; 9 valid pulses total; last window {12,13,14},{17,18,19},{22,23,24}.
REQ-027 Row boundary: no window_valid after pixels 15, 16, 20, 21; valid after 17 with window {5,6,7},{10,11,12},{15,16,17}.
REQ-028 data_valid toggled every cycle (1,0,1,0...) -> same 9 windows, same contents, same order; window_valid never high in a cycle following data_valid = 0.
REQ-029 frame_done pulses once, one cycle after pixel 24; second back-to-back frame (values 100..124) -> first window {100,101,102},{105,106,107},{110,111,112}, 9 pulses, no leakage of frame-1 data.
REQ-030 reset_n low for 2 cycles after pixel 7 -> outputs 0 immediately (asynchronous); restart with 0..24 -> behaviour identical to REQ-026.

Source files
------------

// File: rtl/window_buffer.sv
// Sliding KxK window generator over a raster-order pixel stream.
// Ports:
//   clock, reset_n          - rising-edge clock, async active-low reset
//   data_valid              - qualifies pixel_in_data on a rising edge
//   pixel_in_data           - row-major unsigned pixel stream
//   window_data             - KxK window, element (r,c) at (r*K+c)*DATA_SIZE
//   window_valid            - window_data holds a complete in-frame window
//   frame_done              - one-cycle pulse with the final window of a frame
module window_buffer #(
    parameter int DATA_SIZE   = 8,
    parameter int IMG_WIDTH   = 28,
    parameter int IMG_HEIGHT  = 28,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                                       clock,
    input  logic                                       reset_n,
    input  logic                                       data_valid,
    input  logic [DATA_SIZE-1:0]                       pixel_in_data,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_SIZE-1:0] window_data,
    output logic                                       window_valid,
    output logic                                       frame_done
);

    localparam int K  = KERNEL_SIZE;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);

    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic [DATA_SIZE-1:0] line_buf [K-1][IMG_WIDTH];
    logic [DATA_SIZE-1:0] win      [K][K];
    logic                 col_last;
    logic                 row_last;

    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col <= '0;
            row <= '0;
        end else if (data_valid) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Line buffers are never cleared: stale rows are masked by the
    // row gate on window_valid at the start of each frame.
    always_ff @(posedge clock) begin
        if (data_valid) begin
            for (int k = 0; k < K - 2; k++) begin
                line_buf[k][col] <= line_buf[k+1][col];
            end
            line_buf[K-2][col] <= pixel_in_data;
        end
    end

    // Window shifts left; the right column takes the pre-update
    // line-buffer outputs plus the incoming pixel.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (data_valid) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
            end
            for (int r = 0; r < K - 1; r++) begin
                win[r][K-1] <= line_buf[r][col];
            end
            win[K-1][K-1] <= pixel_in_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            window_valid <= data_valid && (row >= ROW_MIN)
                            && (col >= COL_MIN);
            frame_done   <= data_valid && col_last && row_last;
        end
    end

    always_comb begin
        window_data = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                window_data[(r*K+c)*DATA_SIZE +: DATA_SIZE] = win[r][c];
            end
        end
    end

endmodule
